if_id_stage: RTL and testbench
==============================

# if_id_stage

Fetch-to-decode boundary of the five-stage pipeline CPU: the receiving end of the program counter's `curPC` and the source of its `PCdelay`/`prePC` controls. It captures the fetched instruction and its address into the IF/ID register and detects load-use hazards. It stalls the PC and IF/ID on a hazard, and flushes IF/ID when a taken branch/jump (`PCSrc`) redirects the PC. It also keeps saturating stall/flush event counters for debug.

## Interface
- `NOP`, 32'h0000_0000: instruction word injected on flush.
- `CNT_W`, 16: width of the event counters.

- `CLK` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `curPC` in 32: address currently presented to instruction memory.
- `InstrIn` in 32: instruction memory read data for `curPC` (combinational read).
- `PCSrc` in 1: branch/jump taken, resolved in EX; PC loads ALU target next edge.
- `ID_EX_MemRead` in 1: instruction now in EX is a load.
- `ID_EX_Rt` in 5: destination register of that load.
- `PCdelay` out 1: PC loads `prePC` instead of advancing.
- `prePC` out 32: address the PC reloads while `PCdelay`=1.
- `IF_ID_PC` out 32: registered address of the decode-stage instruction.
- `IF_ID_Instr` out 32: registered decode-stage instruction.
- `IF_ID_Valid` out 1: decode-stage instruction is real (not a bubble).
- `Bubble` out 1: zero the ID/EX control fields this cycle.
- `StallCnt` out CNT_W: number of stall cycles, saturating.
- `FlushCnt` out CNT_W: number of flush events, saturating.

## Operation
- Hazard (combinational): `hz` = `ID_EX_MemRead` & `IF_ID_Valid` & (`ID_EX_Rt` != 0) & (`ID_EX_Rt` == `IF_ID_Instr[25:21]` | `ID_EX_Rt` == `IF_ID_Instr[20:16]`).
- The FSM has three states, encoded in the package:
  - RUN: normal capture.
  - STALL: the cycle after a hazard.
  - FLUSH: the cycle after a redirect.
- Events are evaluated each edge with priority `PCSrc` > `hz` > normal.
- Normal capture:
  - IF_ID_PC←`curPC`, IF_ID_Instr←`InstrIn`, IF_ID_Valid←1.
  - Next state is RUN.
- Stall (`hz`=1, `PCSrc`=0):
  - `PCdelay`=1 and `prePC`=`curPC` combinationally in the same cycle, so the PC holds its value.
  - `Bubble`=1 in the same cycle.
  - IF/ID holds its contents.
  - StallCnt increments.
  - Next state is STALL.
- Flush (`PCSrc`=1):
  - `PCdelay`=0, so the PC takes the branch target.
  - IF_ID_Instr←`NOP`, IF_ID_Valid←0, IF_ID_PC←`curPC`.
  - `Bubble`=1 in the same cycle.
  - FlushCnt increments.
  - Next state is FLUSH.
  - A pending `hz` is discarded.
- STALL state:
  - The load has moved to MEM, so `hz` cannot re-fire for the same load.
  - A new `hz` against a different load stalls again and stays in STALL; each stall cycle is counted.
- FLUSH state:
  - IF_ID_Valid=0, so `hz` is masked.
  - The next edge captures the branch-target instruction; a second consecutive `PCSrc` flushes again.
- Outside a stall, `PCdelay`=0 and `prePC`=`curPC` (don't-care to the PC).
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values:
  - IF_ID_PC=0, IF_ID_Instr=`NOP`, IF_ID_Valid=0.
  - StallCnt=0, FlushCnt=0, state RUN.
  - `PCdelay`=0, `Bubble`=0.
  - These hold while `Reset`=1, independent of `CLK`.
- Reset deasserted mid-stall: the first edge after deassert is a normal capture of `curPC` (0) and `InstrIn`.
- IF/ID latency is one edge: the instruction at `curPC` in cycle n appears on `IF_ID_*` in cycle n+1.
- `PCdelay`, `prePC` and `Bubble` are combinational from registered IF/ID state and the EX/branch inputs; there is no added latency.
- Load-use costs exactly 1 stall cycle.
- A taken branch costs 1 flushed IF/ID slot; flushing ID/EX is handled by `Bubble`.
- `PCSrc` and `hz` asserted in the same cycle: flush only, StallCnt unchanged, `PCdelay`=0.

## Structure
- Shared package `pipe_pkg`:
  - `NOP` constant.
  - rs/rt field bit positions.
  - IF/ID FSM state encoding.
  - CNT_W default.
- One natural sub-module: `hazard_detect`, the combinational `hz` compare, reused later by forwarding logic.
- Everything else is flat in `if_id_stage`.

## Test plan
- Reset:
  - Assert `Reset` asynchronously mid-cycle with IF/ID full.
  - Required: outputs go to reset values immediately, IF_ID_Valid=0, counters 0.
- Straight-line fetch:
  - Drive `curPC`=0,4,8 with `InstrIn`=32'h8C08_0000, 32'h0109_5020, 32'h0000_0000.
  - Required: IF_ID_PC/IF_ID_Instr follow one edge later, IF_ID_Valid=1, `PCdelay`=0 throughout.
- Load-use:
  - IF_ID_Instr=32'h0109_5020 (rs=8), `ID_EX_MemRead`=1, `ID_EX_Rt`=8, `curPC`=32'h0C.
  - Required: same cycle `PCdelay`=1, `prePC`=32'h0C, `Bubble`=1.
  - Required: IF/ID unchanged after the edge and StallCnt=1.
  - Required: the next cycle, with the hazard clear, `PCdelay`=0.
- `ID_EX_Rt`=0 with MemRead=1 and a matching rs=0:
  - Required: no stall, `PCdelay`=0.
- Branch flush with a concurrent hazard:
  - `PCSrc`=1 together with `hz`=1.
  - Required: `PCdelay`=0, IF_ID_Instr=`NOP`, IF_ID_Valid=0.
  - Required: FlushCnt=1 and StallCnt=0.
  - Required: the next edge captures the target instruction with Valid=1.
- Saturation:
  - CNT_W=2, 5 back-to-back stalls against different loads.
  - Required: StallCnt reaches 3 and holds at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction field positions, the injected NOP word,
// IF/ID control-state encoding and the default width of the debug event counters.
package pipe_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam int CNT_W_DEF = 16;

  // IF/ID state: RUN captures, STALL follows a load-use hold, FLUSH follows a redirect
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  function automatic logic [4:0] rsField(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] rtField(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use compare between the load in EX and the source registers of the decode-stage
// instruction; kept separate so the forwarding unit can reuse the same match.
module hazard_detect (
  input  logic       i_exMemRead,
  input  logic [4:0] i_exRt,
  input  logic       i_idValid,
  input  logic [4:0] i_idRs,
  input  logic [4:0] i_idRt,
  output logic       o_hz
);

  logic w_rsMatch;
  logic w_rtMatch;
  logic w_rtNonZero;

  // Register 0 is hardwired, so a load targeting it can never create a dependency
  assign w_rtNonZero = (i_exRt != 5'd0);
  assign w_rsMatch   = (i_exRt == i_idRs);
  assign w_rtMatch   = (i_exRt == i_idRt);

  assign o_hz = i_exMemRead & i_idValid & w_rtNonZero & (w_rsMatch | w_rtMatch);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush and saturating debug counters.
// Drives the PC hold controls combinationally from the registered decode-stage state.
module if_id_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP   = NOP_WORD,
  parameter int          CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [31:0]      curPC,
  input  logic [31:0]      InstrIn,
  input  logic             PCSrc,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  output logic             PCdelay,
  output logic [31:0]      prePC,
  output logic [31:0]      IF_ID_PC,
  output logic [31:0]      IF_ID_Instr,
  output logic             IF_ID_Valid,
  output logic             Bubble,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_ifIdPc;
  logic [31:0]      r_ifIdInstr;
  logic             r_ifIdValid;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic [4:0] w_idRs;
  logic [4:0] w_idRt;
  logic       w_idLive;
  logic       w_hz;
  logic       w_stall;

  assign w_idRs = rsField(r_ifIdInstr);
  assign w_idRt = rtField(r_ifIdInstr);

  // A flushed slot is a bubble and must never stall the PC
  assign w_idLive = r_ifIdValid & (r_state != ST_FLUSH);

  hazard_detect u_hazard (
    .i_exMemRead (ID_EX_MemRead),
    .i_exRt      (ID_EX_Rt),
    .i_idValid   (w_idLive),
    .i_idRs      (w_idRs),
    .i_idRt      (w_idRt),
    .o_hz        (w_hz)
  );

  // A redirect outranks a stall: the stalled instruction is on the wrong path anyway
  assign w_stall = w_hz & ~PCSrc;

  assign PCdelay = w_stall;
  assign prePC   = curPC;
  assign Bubble  = w_hz | PCSrc;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ifIdPc    <= 32'h0000_0000;
      r_ifIdInstr <= NOP;
      r_ifIdValid <= 1'b0;
      r_state     <= ST_RUN;
    end else if (PCSrc) begin
      r_ifIdPc    <= curPC;
      r_ifIdInstr <= NOP;
      r_ifIdValid <= 1'b0;
      r_state     <= ST_FLUSH;
    end else if (w_stall) begin
      r_state     <= ST_STALL;
    end else begin
      r_ifIdPc    <= curPC;
      r_ifIdInstr <= InstrIn;
      r_ifIdValid <= 1'b1;
      r_state     <= ST_RUN;
    end
  end

  // Counters stick at all-ones so a long debug run never reports a small wrapped value
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stall && (r_stallCnt != CNT_MAX)) begin
        r_stallCnt <= r_stallCnt + CNT_ONE;
      end
      if (PCSrc && (r_flushCnt != CNT_MAX)) begin
        r_flushCnt <= r_flushCnt + CNT_ONE;
      end
    end
  end

  assign IF_ID_PC    = r_ifIdPc;
  assign IF_ID_Instr = r_ifIdInstr;
  assign IF_ID_Valid = r_ifIdValid;
  assign StallCnt    = r_stallCnt;
  assign FlushCnt    = r_flushCnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a full-width instance and a 2-bit-counter instance share stimulus
// and are compared every cycle against a pipeline model, plus hand-computed spot checks.
module tb_if_id_stage;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] curPC = 32'h0;
  logic [31:0] InstrIn = 32'h0;
  logic        PCSrc = 1'b0;
  logic        ID_EX_MemRead = 1'b0;
  logic [4:0]  ID_EX_Rt = 5'd0;

  logic        aPCdelay, bPCdelay;
  logic [31:0] aPrePC, bPrePC;
  logic [31:0] aPc, bPc;
  logic [31:0] aInstr, bInstr;
  logic        aValid, bValid;
  logic        aBubble, bBubble;
  logic [15:0] aStall, aFlush;
  logic [1:0]  bStall, bFlush;

  int vectors = 0;
  int miscompares = 0;

  // Model state: what IF/ID holds, and unbounded event tallies
  logic [31:0] mPc = 32'h0;
  logic [31:0] mInstr = 32'h0;
  logic        mValid = 1'b0;
  int          mStalls = 0;
  int          mFlushes = 0;

  if_id_stage dutA (
    .CLK(CLK), .Reset(Reset), .curPC(curPC), .InstrIn(InstrIn), .PCSrc(PCSrc),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .PCdelay(aPCdelay), .prePC(aPrePC), .IF_ID_PC(aPc), .IF_ID_Instr(aInstr),
    .IF_ID_Valid(aValid), .Bubble(aBubble), .StallCnt(aStall), .FlushCnt(aFlush)
  );

  if_id_stage #(.CNT_W(2)) dutB (
    .CLK(CLK), .Reset(Reset), .curPC(curPC), .InstrIn(InstrIn), .PCSrc(PCSrc),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .PCdelay(bPCdelay), .prePC(bPrePC), .IF_ID_PC(bPc), .IF_ID_Instr(bInstr),
    .IF_ID_Valid(bValid), .Bubble(bBubble), .StallCnt(bStall), .FlushCnt(bFlush)
  );

  always #5 CLK = ~CLK;

  function automatic logic modelHazard();
    int rs;
    int rt;
    rs = int'((mInstr >> 21) % 32);
    rt = int'((mInstr >> 16) % 32);
    return ID_EX_MemRead && mValid && (int'(ID_EX_Rt) != 0) &&
           ((int'(ID_EX_Rt) == rs) || (int'(ID_EX_Rt) == rt));
  endfunction

  function automatic int capAt(input int n, input int maxVal);
    return (n > maxVal) ? maxVal : n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipeline model: a redirect squashes the slot, a load-use dependency freezes it,
  // otherwise the fetched word moves into decode
  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mPc = 32'h0; mInstr = 32'h0; mValid = 1'b0; mStalls = 0; mFlushes = 0;
    end else if (PCSrc) begin
      mPc = curPC; mInstr = 32'h0; mValid = 1'b0; mFlushes = mFlushes + 1;
    end else if (modelHazard()) begin
      mStalls = mStalls + 1;
    end else begin
      mPc = curPC; mInstr = InstrIn; mValid = 1'b1;
    end
  end

  // Every cycle, away from the active edge, both instances must agree with the model
  always @(negedge CLK) begin
    logic hz;
    hz = modelHazard();
    checkOutput("A.IF_ID_PC", aPc, mPc);
    checkOutput("A.IF_ID_Instr", aInstr, mInstr);
    checkOutput("A.IF_ID_Valid", {31'b0, aValid}, {31'b0, mValid});
    checkOutput("A.PCdelay", {31'b0, aPCdelay}, {31'b0, hz && !PCSrc && !Reset});
    checkOutput("A.Bubble", {31'b0, aBubble}, {31'b0, (hz || PCSrc) && !Reset});
    checkOutput("A.prePC", aPrePC, curPC);
    checkOutput("A.StallCnt", {16'b0, aStall}, 32'(capAt(mStalls, 65535)));
    checkOutput("A.FlushCnt", {16'b0, aFlush}, 32'(capAt(mFlushes, 65535)));
    checkOutput("B.IF_ID_PC", bPc, mPc);
    checkOutput("B.IF_ID_Instr", bInstr, mInstr);
    checkOutput("B.IF_ID_Valid", {31'b0, bValid}, {31'b0, mValid});
    checkOutput("B.PCdelay", {31'b0, bPCdelay}, {31'b0, hz && !PCSrc && !Reset});
    checkOutput("B.Bubble", {31'b0, bBubble}, {31'b0, (hz || PCSrc) && !Reset});
    checkOutput("B.prePC", bPrePC, curPC);
    checkOutput("B.StallCnt", {30'b0, bStall}, 32'(capAt(mStalls, 3)));
    checkOutput("B.FlushCnt", {30'b0, bFlush}, 32'(capAt(mFlushes, 3)));
  end

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                               input logic br, input logic memRd, input logic [4:0] rt);
    curPC = pc;
    InstrIn = instr;
    PCSrc = br;
    ID_EX_MemRead = memRd;
    ID_EX_Rt = rt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;

    // Straight-line fetch
    applyStimulus(32'h0, 32'h8C08_0000, 1'b0, 1'b0, 5'd0);
    tick();
    checkOutput("fetch0.pc", aPc, 32'h0);
    checkOutput("fetch0.instr", aInstr, 32'h8C08_0000);
    checkOutput("fetch0.valid", {31'b0, aValid}, 32'd1);
    applyStimulus(32'h4, 32'h0109_5020, 1'b0, 1'b0, 5'd0);
    tick();
    checkOutput("fetch4.pc", aPc, 32'h4);
    checkOutput("fetch4.instr", aInstr, 32'h0109_5020);
    applyStimulus(32'h8, 32'h0000_0000, 1'b0, 1'b0, 5'd0);
    tick();
    checkOutput("fetch8.pc", aPc, 32'h8);
    checkOutput("fetch8.instr", aInstr, 32'h0);
    checkOutput("fetch8.pcdelay", {31'b0, aPCdelay}, 32'd0);

    // Load-use: decode holds add with rs=8, EX holds a load to r8
    applyStimulus(32'h8, 32'h0109_5020, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(32'h0C, 32'h8D2A_0004, 1'b0, 1'b1, 5'd8);
    #2;
    checkOutput("lu.pcdelay", {31'b0, aPCdelay}, 32'd1);
    checkOutput("lu.prePC", aPrePC, 32'h0C);
    checkOutput("lu.bubble", {31'b0, aBubble}, 32'd1);
    tick();
    checkOutput("lu.holdPc", aPc, 32'h8);
    checkOutput("lu.holdInstr", aInstr, 32'h0109_5020);
    checkOutput("lu.stallCnt", {16'b0, aStall}, 32'd1);
    applyStimulus(32'h0C, 32'h8D2A_0004, 1'b0, 1'b0, 5'd0);
    #2;
    checkOutput("lu.clear", {31'b0, aPCdelay}, 32'd0);
    tick();
    checkOutput("lu.resume", aPc, 32'h0C);

    // Load to r0 against rs=0 must not stall
    applyStimulus(32'h10, 32'h0000_0000, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(32'h14, 32'h0000_0000, 1'b0, 1'b1, 5'd0);
    #2;
    checkOutput("r0.pcdelay", {31'b0, aPCdelay}, 32'd0);
    tick();
    checkOutput("r0.capture", aPc, 32'h14);
    checkOutput("r0.stallCnt", {16'b0, aStall}, 32'd1);

    // Branch redirect with a simultaneous hazard on rt=9
    applyStimulus(32'h18, 32'h0109_5020, 1'b0, 1'b0, 5'd0);
    tick();
    applyStimulus(32'h1C, 32'h1234_5678, 1'b1, 1'b1, 5'd9);
    #2;
    checkOutput("br.pcdelay", {31'b0, aPCdelay}, 32'd0);
    checkOutput("br.bubble", {31'b0, aBubble}, 32'd1);
    tick();
    checkOutput("br.instr", aInstr, 32'h0);
    checkOutput("br.valid", {31'b0, aValid}, 32'd0);
    checkOutput("br.flushCnt", {16'b0, aFlush}, 32'd1);
    checkOutput("br.stallCnt", {16'b0, aStall}, 32'd1);
    applyStimulus(32'h40, 32'hAC0A_0000, 1'b0, 1'b1, 5'd9);
    #2;
    checkOutput("br.masked", {31'b0, aPCdelay}, 32'd0);
    tick();
    checkOutput("br.targetPc", aPc, 32'h40);
    checkOutput("br.targetInstr", aInstr, 32'hAC0A_0000);
    checkOutput("br.targetValid", {31'b0, aValid}, 32'd1);

    // Back-to-back stalls: decode reads r10, a string of loads to r10 in EX
    applyStimulus(32'h44, 32'h1111_1111, 1'b0, 1'b1, 5'd10);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) checkOutput("sat.reach", {30'b0, bStall}, 32'd3);
    end
    checkOutput("sat.hold", {30'b0, bStall}, 32'd3);
    checkOutput("sat.wide", {16'b0, aStall}, 32'd6);
    checkOutput("sat.ifid", aPc, 32'h40);
    applyStimulus(32'h44, 32'h1111_1111, 1'b0, 1'b0, 5'd0);
    tick();

    // Asynchronous reset mid-cycle with IF/ID full
    #3 Reset = 1'b1;
    #1;
    checkOutput("rst.pc", aPc, 32'h0);
    checkOutput("rst.instr", aInstr, 32'h0);
    checkOutput("rst.valid", {31'b0, aValid}, 32'd0);
    checkOutput("rst.stallCnt", {16'b0, aStall}, 32'd0);
    checkOutput("rst.flushCnt", {16'b0, aFlush}, 32'd0);
    checkOutput("rst.pcdelay", {31'b0, aPCdelay}, 32'd0);

    // Release reset while a would-be hazard is presented; first edge is a plain capture
    applyStimulus(32'h0, 32'h0109_5020, 1'b0, 1'b1, 5'd8);
    tick();
    #2 Reset = 1'b0;
    tick();
    checkOutput("rel.pc", aPc, 32'h0);
    checkOutput("rel.instr", aInstr, 32'h0109_5020);
    checkOutput("rel.valid", {31'b0, aValid}, 32'd1);
    checkOutput("rel.stallCnt", {16'b0, aStall}, 32'd0);
    applyStimulus(32'h4, 32'h0, 1'b0, 1'b0, 5'd0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
